// File: rtl/zn_wlx_fsk_mod.sv
// rtl/zn_wlx_fsk_mod.sv - binary FSK modulator, UART-framed bytes to a phase-continuous triangle DAC stream
module zn_wlx_fsk_mod #(
    parameter logic [15:0] FTW_MARK    = 16'd2048,
    parameter logic [15:0] FTW_SPACE   = 16'd1024,
    parameter int          BIT_SAMPLES = 256
) (
    input  logic       sample_clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_bit,
    output logic [7:0] dac_out
);

    localparam logic [15:0] LAST_SAMPLE = 16'(BIT_SAMPLES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic [15:0] phase;
    logic [15:0] sample_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [15:0] ftw;
    logic [15:0] phase_next;
    logic        bit_end;

    function automatic logic [7:0] tri_wave(input logic [15:0] ph);
        logic [7:0] ramp;
        ramp = {ph[14:8], 1'b0};
        return ph[15] ? ~ramp : ramp;
    endfunction

    assign tx_ready   = (state == IDLE);
    assign ftw        = tx_bit ? FTW_MARK : FTW_SPACE;
    assign phase_next = phase + ftw;
    assign bit_end    = (sample_cnt == LAST_SAMPLE);

    // Phase runs on every edge regardless of state so tone switches stay continuous.
    always_ff @(posedge sample_clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            phase      <= 16'd0;
            sample_cnt <= 16'd0;
            bit_idx    <= 3'd0;
            shift_reg  <= 8'd0;
            dac_out    <= 8'd0;
            tx_bit     <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            phase   <= phase_next;
            dac_out <= tri_wave(phase_next);
            case (state)
                IDLE: begin
                    tx_bit  <= 1'b1;
                    tx_busy <= 1'b0;
                    if (tx_valid) begin
                        shift_reg  <= tx_data;
                        state      <= START;
                        sample_cnt <= 16'd0;
                        tx_bit     <= 1'b0;
                        tx_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state      <= DATA;
                        bit_idx    <= 3'd0;
                        tx_bit     <= shift_reg[0];
                        sample_cnt <= 16'd0;
                    end else begin
                        sample_cnt <= sample_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        sample_cnt <= 16'd0;
                        if (bit_idx != 3'd7) begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx_bit    <= shift_reg[1];
                        end else begin
                            state  <= STOP;
                            tx_bit <= 1'b1;
                        end
                    end else begin
                        sample_cnt <= sample_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state      <= IDLE;
                        tx_busy    <= 1'b0;
                        sample_cnt <= 16'd0;
                    end else begin
                        sample_cnt <= sample_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zn_wlx_fsk_mod.sv
// tb/tb_zn_wlx_fsk_mod.sv - self-checking bench for zn_wlx_fsk_mod against a sample-level reference model
module tb_zn_wlx_fsk_mod;

    localparam int BS = 256;

    logic       sample_clk = 1'b0;
    logic       rst        = 1'b0;
    logic [7:0] tx_data    = 8'd0;
    logic       tx_valid   = 1'b0;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_bit;
    logic [7:0] dac_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: phase as a plain integer, line bits as a queue of per-sample values.
    int m_phase = 0;
    int m_dac   = 0;
    bit m_bit   = 1'b1;
    bit m_busy  = 1'b0;
    bit line_q[$];

    zn_wlx_fsk_mod dut (
        .sample_clk (sample_clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_bit     (tx_bit),
        .dac_out    (dac_out)
    );

    always #5 sample_clk = ~sample_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_dac   = 0;
        m_bit   = 1'b1;
        m_busy  = 1'b0;
        line_q.delete();
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dac_out"}, 32'(dac_out), 32'(m_dac));
        check({tag, ".tx_bit"}, 32'(tx_bit), 32'(m_bit));
        check({tag, ".tx_busy"}, 32'(tx_busy), 32'(m_busy));
        check({tag, ".tx_ready"}, 32'(tx_ready), 32'(!m_busy));
    endtask

    task automatic step();
        int p;
        bit b;
        @(posedge sample_clk);
        m_phase = (m_phase + (m_bit ? 2048 : 1024)) % 65536;
        p       = m_phase / 256;
        m_dac   = (p < 128) ? 2 * p : 255 - 2 * (p - 128);
        if (!m_busy && tx_valid) begin
            for (int k = 0; k < 10; k++) begin
                b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : tx_data[k-1];
                for (int s = 0; s < BS; s++) line_q.push_back(b);
            end
        end
        if (line_q.size() > 0) begin
            m_bit  = line_q.pop_front();
            m_busy = 1'b1;
        end else begin
            m_bit  = 1'b1;
            m_busy = 1'b0;
        end
        #1;
        check_outputs("step");
    endtask

    initial begin
        int         busy_cnt;
        int         low_cnt;
        logic [9:0] bits_seen;

        model_reset();
        #12;
        check_outputs("reset");
        @(negedge sample_clk);
        rst = 1'b1;

        // Idle mark tone
        for (int i = 0; i < 40; i++) step();
        check("mark_dac_after_40", 32'(dac_out), 32'd128);

        // Single frame 0xA5
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step();
        tx_valid  = 1'b0;
        tx_data   = 8'($urandom);
        busy_cnt  = (tx_busy === 1'b1) ? 1 : 0;
        bits_seen = 10'd0;
        for (int i = 0; i < 2600; i++) begin
            if (i % BS == 100) bits_seen[i / BS] = tx_bit;
            step();
            if (tx_busy === 1'b1) busy_cnt++;
        end
        check("a5_bit_sequence", 32'(bits_seen), 32'(10'b1101001010));
        check("a5_busy_edges", 32'(busy_cnt), 32'd2560);

        // Back-to-back 0x00 then 0xFF with valid held
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        step();
        tx_data = 8'hFF;
        low_cnt = 0;
        for (int i = 0; i < 3000 && tx_ready !== 1'b1; i++) begin
            low_cnt++;
            step();
        end
        check("b2b_ready_low", 32'(low_cnt), 32'd2560);
        step();
        tx_valid = 1'b0;
        check("b2b_second_accepted", 32'(tx_busy), 32'd1);
        for (int i = 0; i < 2600; i++) step();

        // Mid-frame valid pulse must be ignored
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 1000; i++) step();
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 1900; i++) step();
        check("ignored_no_extra_frame", 32'(tx_busy), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 6000; i++) begin
            tx_valid = ($urandom % 8 == 0);
            tx_data  = 8'($urandom);
            step();
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 2600; i++) step();

        // Asynchronous reset during data bit 4
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        for (int i = 0; i < 5 * BS + 100; i++) step();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge sample_clk);
        rst = 1'b1;
        for (int i = 0; i < 40; i++) step();
        check("post_reset_mark", 32'(dac_out), 32'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
